// File: rtl/sigma_delta_adc_sched.sv
// Sequencer and round-robin merger for a bank of sigma-delta ADCs.
// Each channel runs OFF -> SETTLE -> LIVE; live samples feed one tagged stream.
module sigma_delta_adc_sched #(
    parameter int NUM_CH         = 4,
    parameter int ADC_BITLEN     = 16,
    parameter int SETTLE_SAMPLES = 2,
    parameter int CH_W           = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_enable,
    output logic [NUM_CH-1:0]            adc_rst,
    input  logic [NUM_CH*ADC_BITLEN-1:0] adc_data,
    input  logic [NUM_CH-1:0]            adc_valid,
    output logic [ADC_BITLEN-1:0]        m_data,
    output logic [CH_W-1:0]              m_chan,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [NUM_CH-1:0]            ch_live,
    output logic [NUM_CH-1:0]            ovf,
    input  logic                         ovf_clr
);

    typedef enum logic [1:0] {OFF, SETTLE, LIVE} state_t;

    localparam int CNT_W = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);

    state_t                state    [NUM_CH];
    state_t                state_nx [NUM_CH];
    logic [CNT_W-1:0]      cnt      [NUM_CH];
    logic [CNT_W-1:0]      cnt_nx   [NUM_CH];
    logic [ADC_BITLEN-1:0] pdata    [NUM_CH];
    logic [NUM_CH-1:0]     pend;
    logic [NUM_CH-1:0]     req;
    logic [NUM_CH-1:0]     gnt_vec;
    logic [CH_W-1:0]       last_grant;
    logic [CH_W-1:0]       gnt_ch;
    logic                  gnt;
    logic                  free;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_nx[i] = state[i];
            cnt_nx[i]   = cnt[i];
            adc_rst[i]  = 1'b1;
            ch_live[i]  = 1'b0;
            unique case (state[i])
                OFF: begin
                    cnt_nx[i] = '0;
                    if (ch_enable[i])
                        state_nx[i] = (SETTLE_SAMPLES == 0) ? LIVE : SETTLE;
                end
                SETTLE: begin
                    adc_rst[i] = 1'b0;
                    if (adc_valid[i]) begin
                        if (cnt[i] == CNT_LAST)
                            state_nx[i] = LIVE;
                        else
                            cnt_nx[i] = cnt[i] + 1'b1;
                    end
                end
                LIVE: begin
                    adc_rst[i] = 1'b0;
                    ch_live[i] = 1'b1;
                end
                default: state_nx[i] = OFF;
            endcase
            if (!ch_enable[i]) begin
                state_nx[i] = OFF;
                cnt_nx[i]   = '0;
            end
        end
    end

    // A channel being disabled this cycle is not eligible, so its held sample is never emitted.
    always_comb begin
        int idx;
        idx     = 0;
        free    = !m_valid || m_ready;
        req     = pend & ch_enable;
        gnt     = 1'b0;
        gnt_ch  = '0;
        gnt_vec = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_grant) + k) % NUM_CH;
            if (free && !gnt && req[idx]) begin
                gnt    = 1'b1;
                gnt_ch = CH_W'(idx);
            end
        end
        if (gnt)
            gnt_vec[gnt_ch] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= OFF;
                cnt[i]   <= '0;
                pdata[i] <= '0;
            end
            pend       <= '0;
            ovf        <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_chan     <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= state_nx[i];
                cnt[i]   <= cnt_nx[i];
                if (!ch_enable[i]) begin
                    pend[i] <= 1'b0;
                end else if (state[i] == LIVE && adc_valid[i] &&
                             (!pend[i] || gnt_vec[i])) begin
                    pend[i]  <= 1'b1;
                    pdata[i] <= adc_data[i*ADC_BITLEN +: ADC_BITLEN];
                end else if (gnt_vec[i]) begin
                    pend[i] <= 1'b0;
                end
                // A fresh drop outranks a simultaneous clear.
                if (state[i] == LIVE && ch_enable[i] && adc_valid[i] &&
                    pend[i] && !gnt_vec[i])
                    ovf[i] <= 1'b1;
                else if (ovf_clr)
                    ovf[i] <= 1'b0;
            end
            if (gnt) begin
                m_valid    <= 1'b1;
                m_data     <= pdata[gnt_ch];
                m_chan     <= gnt_ch;
                last_grant <= gnt_ch;
            end else if (free) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
